muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit with its own sequencer.
// Runs a radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop,
// one bit per cycle, while holding the upstream pipeline with stall.
// Ports:
//   clk, rst        - clock (rising edge), synchronous active-high reset
//   start, op       - request and opcode (0 MUL, 1 MULH, 2 DIV, 3 DIVU, 4 REM, 5 REMU, 6/7 MUL)
//   op_a, op_b      - rs1 / rs2 operand values
//   rd_in           - destination register id travelling with the op
//   flush           - synchronous abort; returns to IDLE without a result
//   stall           - hold upstream pipeline while an op is accepted or in flight
//   valid_out       - one-cycle pulse; result and rd_out are valid
//   result, rd_out  - registered result and destination id
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int ID_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [ID_W-1:0]  rd_in,
  input  logic             flush,
  output logic             stall,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic [ID_W-1:0]  rd_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SPECIAL, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_counter;
  logic [2:0]         r_op;
  logic [ID_W-1:0]    r_rd;
  logic               r_neg_q;     // quotient / MULH product must be negated
  logic               r_neg_r;     // remainder must be negated (dividend sign)
  logic [2*WIDTH-1:0] r_acc;       // product accumulator
  logic [2*WIDTH-1:0] r_x;         // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   r_y;         // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [WIDTH-1:0]   r_b;         // divisor magnitude
  logic [WIDTH-1:0]   r_rem;       // partial remainder, always < divisor
  logic [WIDTH-1:0]   r_sp_res;    // result precomputed for divide-by-zero / overflow
  logic [WIDTH-1:0]   r_result;
  logic [ID_W-1:0]    r_rd_out;

  // Request-side decode and special-case detection at latch time.
  logic             w_accept, w_in_signed, w_in_div, w_a_neg, w_b_neg;
  logic             w_div_zero, w_ovf, w_special;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_sp_res;

  assign w_accept    = (r_state == S_IDLE) && start && !flush;
  assign w_in_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4);
  assign w_in_div    = (op >= 3'd2) && (op <= 3'd5);
  assign w_a_neg     = w_in_signed && op_a[WIDTH-1];
  assign w_b_neg     = w_in_signed && op_b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? -op_a : op_a;
  assign w_b_mag     = w_b_neg ? -op_b : op_b;
  assign w_div_zero  = w_in_div && (op_b == '0);
  assign w_ovf       = ((op == 3'd2) || (op == 3'd4)) &&
                       (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
  assign w_special   = w_div_zero || w_ovf;

  always_comb begin
    w_sp_res = '0;
    if (w_div_zero) begin
      w_sp_res = (op == 3'd2 || op == 3'd3) ? '1 : op_a;
    end else if (op == 3'd2) begin
      w_sp_res = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  // One iteration of the datapath.
  logic               w_is_mulh, w_is_div;
  logic [WIDTH:0]     w_shift, w_diff;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rem_next, w_quot_next, w_final;
  logic [2*WIDTH-1:0] w_acc_next, w_prod_s;

  assign w_is_mulh = (r_op == 3'd1);
  assign w_is_div  = (r_op >= 3'd2) && (r_op <= 3'd5);

  // Remainder stays below the divisor, so the (WIDTH+1)-bit difference
  // lies in (-divisor, divisor) and its top bit is the borrow.
  assign w_shift     = {r_rem, r_y[WIDTH-1]};
  assign w_diff      = w_shift - {1'b0, r_b};
  assign w_borrow    = w_diff[WIDTH];
  assign w_rem_next  = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quot_next = {r_y[WIDTH-2:0], ~w_borrow};
  assign w_acc_next  = r_y[0] ? (r_acc + r_x) : r_acc;
  assign w_prod_s    = r_neg_q ? -w_acc_next : w_acc_next;

  // Final result from the last iteration's next values, so it can be
  // registered on the edge into DONE.
  always_comb begin
    w_final = w_acc_next[WIDTH-1:0];
    case (r_op)
      3'd1:    w_final = w_prod_s[2*WIDTH-1:WIDTH];
      3'd2:    w_final = r_neg_q ? -w_quot_next : w_quot_next;
      3'd3:    w_final = w_quot_next;
      3'd4:    w_final = r_neg_r ? -w_rem_next : w_rem_next;
      3'd5:    w_final = w_rem_next;
      default: w_final = w_acc_next[WIDTH-1:0];
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and outputs.
  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    valid_out    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          stall        = 1'b1;
          w_state_next = w_special ? S_SPECIAL : S_RUN;
        end
      end
      S_RUN: begin
        stall = 1'b1;
        if (r_counter == LAST) begin
          w_state_next = S_DONE;
        end
      end
      S_SPECIAL: begin
        stall        = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        valid_out    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (flush) begin
      w_state_next = S_IDLE;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_counter <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_acc     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_b       <= '0;
      r_rem     <= '0;
      r_sp_res  <= '0;
      r_result  <= '0;
      r_rd_out  <= '0;
    end else begin
      if (w_accept) begin
        r_counter <= '0;
        r_op      <= op;
        r_rd      <= rd_in;
        r_neg_q   <= w_a_neg ^ w_b_neg;
        r_neg_r   <= w_a_neg;
        r_acc     <= '0;
        r_x       <= {{WIDTH{1'b0}}, w_a_mag};
        r_y       <= w_in_div ? w_a_mag : w_b_mag;
        r_b       <= w_b_mag;
        r_rem     <= '0;
        r_sp_res  <= w_sp_res;
      end else if (r_state == S_RUN) begin
        r_counter <= r_counter + CNT_W'(1);
        if (w_is_div) begin
          r_rem <= w_rem_next;
          r_y   <= w_quot_next;
        end else begin
          r_acc <= w_acc_next;
          r_x   <= r_x << 1;
          r_y   <= r_y >> 1;
        end
      end
      if (w_state_next == S_DONE) begin
        r_result <= (r_state == S_SPECIAL) ? r_sp_res : w_final;
        r_rd_out <= r_rd;
      end
    end
  end

  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule
